data_mem_responder: RTL

Responder side of the memory-stage load/store interface. Accepts one load or store request at a time from the pipeline's memory stage and executes it against an internal word-addressed RAM with a fixed, parameterised latency. Returns a one-cycle response carrying aligned, sign- or zero-extended read data, or an error flag. Drives `req_ready` low while busy so the pipeline can stall on it.

---
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Memory-stage load/store responder: one request at a time against an internal word RAM,
// fixed LATENCY from accept to a one-cycle registered response.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit          Direct  = (LATENCY == 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic            accept, enter_resp, mem_we;
  logic            a_we, a_uns, a_err;
  logic [1:0]      a_size;
  logic [31:0]     a_addr, a_wdata;
  logic [IdxW-1:0] a_idx;
  logic [31:0]     rd_word, lane, ext, wd;
  logic [3:0]      be;

  assign req_ready_o = ~rst_i & (state_q != StWait);
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (accept) begin
          if (Direct) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // With LATENCY=1 the access edge is the accept edge, so the live request is used.
  assign a_we    = Direct ? req_we_i       : we_q;
  assign a_size  = Direct ? req_size_i     : size_q;
  assign a_uns   = Direct ? req_unsigned_i : uns_q;
  assign a_addr  = Direct ? req_addr_i     : addr_q;
  assign a_wdata = Direct ? req_wdata_i    : wdata_q;
  assign a_idx   = a_addr[IdxW+1:2];

  assign a_err = (a_size == 2'b11)
               | ((a_size == 2'b01) & a_addr[0])
               | ((a_size == 2'b10) & (a_addr[1:0] != 2'b00))
               | ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS));

  assign enter_resp = (state_d == StResp) & ~rst_i;
  assign mem_we     = enter_resp & a_we & ~a_err;

  always_comb begin
    rd_word = mem_q[a_idx];
    lane    = rd_word >> {a_addr[1:0], 3'b000};
    unique case (a_size)
      2'b00:   ext = {{24{~a_uns & lane[7]}}, lane[7:0]};
      2'b01:   ext = {{16{~a_uns & lane[15]}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    unique case (a_size)
      2'b00: begin
        be = 4'b0001 << a_addr[1:0];
        wd = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be = a_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{a_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = a_wdata;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[a_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= req_we_i;
      size_q  <= req_size_i;
      uns_q   <= req_unsigned_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= enter_resp;
      rsp_err_q   <= enter_resp & a_err;
      rsp_rdata_q <= (enter_resp & ~a_we & ~a_err) ? ext : 32'd0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
